// File: rtl/seq_detector_param.sv
// seq_detector_param
// Mealy serial-pattern detector for an N-bit pattern (2..16 bits). It supports
// overlapping or non-overlapping matching and a valid qualifier on the serial
// input. It also provides a registered match pulse and a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   din          serial data bit
//   din_valid    din is consumed on this edge only when high
//   y            Mealy match output (combinational from state and inputs)
//   y_q          y registered, one cycle later
//   match_count  saturating count of matches since reset
//   state        current matched-prefix length (debug / verification)
//
// Handshake: din_valid is a pure qualifier with no backpressure. The bit on
// din is accepted on every rising edge where din_valid = 1 and reset = 0.
// On any other edge the state and the counter hold.
module seq_detector_param #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_count,
  output logic [SW-1:0]    state
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  // The KMP transition for prefix length k and incoming bit b is the longest
  // j <= N-1 such that the first j pattern bits equal the last j bits of
  // (first k pattern bits, b). PATTERN[N-1] is the first pattern bit.
  // Because the cap is N-1, this same function also gives the longest proper
  // border on a full match (k = N-1, b = PATTERN[0]).
  function automatic int kmp_next(input int k, input logic b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int j = 1; j <= N - 1; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < N; m++) begin
          if (m < j) begin
            idx = k + 1 - j + m;
            sb  = (idx == k) ? b : PATTERN[N-1-idx];
            if (sb != PATTERN[N-1-m]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Transition tables, fixed at elaboration. Encoding slack (k >= N) maps
  // to 0, so any unreachable state falls back to the empty prefix.
  logic [SW-1:0] nxt0 [2**SW];
  logic [SW-1:0] nxt1 [2**SW];

  for (genvar k = 0; k < 2**SW; k++) begin : g_tbl
    if (k < N) begin : g_live
      assign nxt0[k] = SW'(kmp_next(k, 1'b0));
      assign nxt1[k] = SW'(kmp_next(k, 1'b1));
    end else begin : g_slack
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  logic [SW-1:0] cs;
  logic [SW-1:0] ns;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs          <= '0;
      y_q         <= 1'b0;
      match_count <= '0;
    end else begin
      cs  <= ns;
      y_q <= y;
      if (y && !(&match_count)) match_count <= match_count + 1'b1;
    end
  end

  always_comb begin
    ns = cs;
    y  = din_valid & ~reset & (cs == LAST) & (din == PATTERN[0]);
    if (din_valid) begin
      if (y && (OVERLAP == 0)) ns = '0;
      else                     ns = din ? nxt1[cs] : nxt0[cs];
    end
  end

  assign state = cs;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Four instances with different parameter sets
// share one input bus. Each test resets all of them and checks only the
// instance it targets. The driver pushes the expected
// {sel, y, state, y_q, match_count} for each driven cycle. The monitor pops
// and compares on the falling edge.
module tb_seq_detector_param;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  always #5 clk = ~clk;

  // u0: defaults (101, overlap)
  logic       y0, yq0;
  logic [1:0] s0;
  logic [7:0] c0;
  // u1: 101, no overlap
  logic       y1, yq1;
  logic [1:0] s1;
  logic [7:0] c1;
  // u2: N=4, 1101, overlap
  logic       y2, yq2;
  logic [1:0] s2;
  logic [7:0] c2;
  // u3: N=2, 11, overlap, CNT_W=2
  logic       y3, yq3;
  logic [0:0] s3;
  logic [1:0] c3;

  seq_detector_param u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .y(y0), .y_q(yq0), .match_count(c0), .state(s0));

  seq_detector_param #(.N(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .y(y1), .y_q(yq1), .match_count(c1), .state(s1));

  seq_detector_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .y(y2), .y_q(yq2), .match_count(c2), .state(s2));

  seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .y(y3), .y_q(yq3), .match_count(c3), .state(s3));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [1:0] cur_sel = 2'd0;
  int prev_s = 0;
  logic prev_y = 1'b0;
  int prev_c = 0;

  logic [W-1:0] rec;
  logic       a_y, a_yq;
  logic [3:0] a_s;
  logic [7:0] a_c;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      case (rec[15:14])
        2'd0:    begin a_y = y0; a_yq = yq0; a_s = {2'b0, s0}; a_c = c0; end
        2'd1:    begin a_y = y1; a_yq = yq1; a_s = {2'b0, s1}; a_c = c1; end
        2'd2:    begin a_y = y2; a_yq = yq2; a_s = {2'b0, s2}; a_c = c2; end
        default: begin a_y = y3; a_yq = yq3; a_s = {3'b0, s3}; a_c = {6'b0, c3}; end
      endcase
      checks = checks + 4;
      if (a_y !== rec[13]) begin
        failures++;
        $display("FAIL y dut=%0d t=%0t got=%b exp=%b", rec[15:14], $time, a_y, rec[13]);
      end
      if (a_s !== rec[12:9]) begin
        failures++;
        $display("FAIL state dut=%0d t=%0t got=%0d exp=%0d", rec[15:14], $time, a_s, rec[12:9]);
      end
      if (a_yq !== rec[8]) begin
        failures++;
        $display("FAIL y_q dut=%0d t=%0t got=%b exp=%b", rec[15:14], $time, a_yq, rec[8]);
      end
      if (a_c !== rec[7:0]) begin
        failures++;
        $display("FAIL match_count dut=%0d t=%0t got=%0d exp=%0d", rec[15:14], $time, a_c, rec[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // ey/es/ec are the hand-computed y for this bit and the state and count
  // after this edge. The pushed record holds what is visible before the edge.
  task automatic drive(input logic d, input logic v, input logic r,
                       input logic ey, input int es, input int ec);
    @(posedge clk);
    #2;
    din = d;
    din_valid = v;
    reset = r;
    exp_q.push_back({cur_sel, ey, prev_s[3:0], prev_y, prev_c[7:0]});
    prev_s = es;
    prev_y = ey;
    prev_c = ec;
  endtask

  task automatic bit_in(input logic d, input logic ey, input int es, input int ec);
    drive(d, 1'b1, 1'b0, ey, es, ec);
  endtask

  task automatic idle();
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, prev_s, prev_c);
  endtask

  task automatic begin_test(input logic [1:0] sel);
    @(posedge clk);
    #2;
    reset = 1'b1;
    din_valid = 1'b0;
    cur_sel = sel;
    prev_s = 0;
    prev_y = 1'b0;
    prev_c = 0;
  endtask

  initial begin
    // T1: defaults, overlap: 1,0,1,0,1,1,0,1 -> hits on bits 3, 5, 8
    begin_test(2'd0);
    bit_in(1, 0, 1, 0);
    bit_in(0, 0, 2, 0);
    bit_in(1, 1, 1, 1);
    bit_in(0, 0, 2, 1);
    bit_in(1, 1, 1, 2);
    bit_in(1, 0, 1, 2);
    bit_in(0, 0, 2, 2);
    bit_in(1, 1, 1, 3);
    idle();

    // T2: no overlap, same stream -> hits on bits 3 and 8
    begin_test(2'd1);
    bit_in(1, 0, 1, 0);
    bit_in(0, 0, 2, 0);
    bit_in(1, 1, 0, 1);
    bit_in(0, 0, 0, 1);
    bit_in(1, 0, 1, 1);
    bit_in(1, 0, 1, 1);
    bit_in(0, 0, 2, 1);
    bit_in(1, 1, 0, 2);
    idle();

    // T3: 1101 overlap: 1,1,0,1,1,0,1 -> states 1,2,3,1,2,3,1
    begin_test(2'd2);
    bit_in(1, 0, 1, 0);
    bit_in(1, 0, 2, 0);
    bit_in(0, 0, 3, 0);
    bit_in(1, 1, 1, 1);
    bit_in(1, 0, 2, 1);
    bit_in(0, 0, 3, 1);
    bit_in(1, 1, 1, 2);
    idle();

    // T4: valid gaps on defaults: 1, 3 idle, 0, 2 idle, 1
    begin_test(2'd0);
    bit_in(1, 0, 1, 0);
    idle(); idle(); idle();
    bit_in(0, 0, 2, 0);
    idle(); idle();
    bit_in(1, 1, 1, 1);
    idle();

    // T5: saturation, pattern 11, CNT_W=2: six 1s
    begin_test(2'd3);
    bit_in(1, 0, 1, 0);
    bit_in(1, 1, 1, 1);
    bit_in(1, 1, 1, 2);
    bit_in(1, 1, 1, 3);
    bit_in(1, 1, 1, 3);
    bit_in(1, 1, 1, 3);
    idle();

    // T6: reset mid-pattern on defaults. The reset edge carries din=1 from
    // state 2, which would otherwise complete a match.
    begin_test(2'd0);
    bit_in(1, 0, 1, 0);
    bit_in(0, 0, 2, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    bit_in(0, 0, 0, 0);
    bit_in(1, 0, 1, 0);
    bit_in(1, 0, 1, 0);
    bit_in(0, 0, 2, 0);
    bit_in(1, 1, 1, 1);
    idle();

    @(posedge clk);
    #2;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Mealy serial-pattern detector. It generalises the fixed 3-bit "101" detector to any pattern of 2..16 bits, with selectable overlapping or non-overlapping matching, a valid qualifier on the serial input, a registered copy of the match pulse and a saturating match counter. It sits on a serial bit stream, one bit per qualified clock, and flags each completed occurrence of `PATTERN`.

## Interface
- `N`, 3: pattern length in bits; legal range 2..16.
- `PATTERN`, 3'b101: `N`-bit pattern. `PATTERN[N-1]` is the first bit received; `PATTERN[0]` is the last.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each hit.
- `CNT_W`, 8: width of the match counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is consumed on this edge only when high.
- `y`  out  1  Mealy match output, combinational from state and inputs.
- `y_q`  out  1  `y` registered; one cycle later than `y`.
- `match_count`  out  CNT_W  number of matches since reset; saturates.
- `state`  out  ceil(log2(N))  current matched-prefix length, for debug and verification.

## Operation
- State `cs` ranges over 0..N-1. It holds the number of pattern-prefix bits currently matched. `cs` = k means the last k accepted bits equal `PATTERN[N-1 -: k]`.
- `y` = `din_valid & ~reset & (cs == N-1) & (din == PATTERN[0])`. There is no other path to `y`.
- Next-state rule, applied on an accepted bit b (`din_valid` = 1):
  - No match: `ns` is the largest k < N such that the last k accepted bits, ending with b, equal the first k pattern bits. This is the KMP failure transition. It is precomputed from `PATTERN` at elaboration, or built as a generate-time table; it is not searched at run time.
  - Match with `OVERLAP` = 1: `ns` is the length of the longest proper border of `PATTERN`. Example: 101 gives 1; 1101 gives 1; 111 gives 2.
  - Match with `OVERLAP` = 0: `ns` = 0.
- When `din_valid` = 0: `cs` holds, `y` = 0, and the counter holds.
- Counter: increments by 1 on every edge where `y` = 1. At all-ones it stays there and does not wrap.
- No illegal states are reachable. If `cs` ≥ N (encoding slack), `ns` = 0 and `y` = 0.
- For the default parameters the behaviour is identical to the fixed 101 overlapping detector:
  - S0: 1 → S1.
  - S1: 0 → S2; 1 → S1.
  - S2: 1 → S1 with `y` = 1; 0 → S0.

## Timing
- Reset (sampled on the rising edge while `reset` = 1): `cs` = 0, `y_q` = 0, `match_count` = 0. `y` is forced to 0 combinationally while `reset` is high.
- Reset mid-pattern discards all partial progress. The first edge after reset deassertion starts matching from S0.
- `y` is valid in the same cycle as the completing `din`. Latency from the completing bit to `y_q` is 1 cycle. Latency from the completing bit to the `match_count` update is 1 cycle.
- Back-to-back matches in overlap mode produce `y` on consecutive accepted bits whenever the pattern border allows it. Example: `PATTERN` = 11, N = 2, input 1,1,1 gives matches on bits 2 and 3.
- `din_valid` gaps of any length do not break a partial match. Matching continues across the gap.
- There are no other inputs, so there are no simultaneous-event conflicts. When `reset` and `din_valid` are both high, reset wins.

## Test plan
- Defaults, overlap. Stream 1,0,1,0,1,1,0,1 (`din_valid` = 1 throughout) → `y` high on bits 3, 5 and 8; `match_count` = 3; `y_q` high on the following cycles.
- `OVERLAP` = 0, `PATTERN` = 101. Same stream → `y` high on bits 3 and 8 only; `match_count` = 2.
- N = 4, `PATTERN` = 4'b1101, overlap. Stream 1,1,0,1,1,0,1 → `y` high on bits 4 and 7. The `state` sequence is 1,2,3,1,2,3,1.
- Valid gaps, defaults. Send 1, then 3 idle cycles, then 0, then 2 idle cycles, then 1 → one match on the final bit. `y` stays 0 and `state` is held during every idle cycle.
- Saturation, `CNT_W` = 2, `PATTERN` = 11, overlap. Six consecutive 1s → 5 matches; `match_count` reads 1, 2, 3, 3, 3.
- Reset mid-operation, defaults. Send 1,0; assert `reset` for one edge with `din` = 1 and `din_valid` = 1 → `y` = 0 and `state` = 0. Then 0,1 → no match. Then 1,0,1 → match on the last bit, and `match_count` = 1.
